// File: rtl/pcie_axi_wr_splitter.sv
// pcie_axi_wr_splitter
// Splits upstream AXI4 INCR write bursts into sub-bursts that stay within one
// MAX_PAYLOAD_SIZE-aligned window, and merges the downstream write responses
// so that every original burst receives exactly one B response.
module pcie_axi_wr_splitter #(
    parameter int ID_WIDTH         = 6,
    parameter int ADDR_WIDTH       = 64,
    parameter int DATA_WIDTH       = 256,
    parameter int MAX_PAYLOAD_SIZE = 128,
    parameter int OUTST_DEPTH_LG2  = 2
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,

    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,

    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,

    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,

    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,

    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp
);

    // Beat-granular view of the payload window; offsets are in 32-byte beats.
    localparam int         MPS_BEATS   = MAX_PAYLOAD_SIZE / 32;
    localparam int         MPS_LG2     = $clog2(MAX_PAYLOAD_SIZE);
    localparam int         FIFO_DEPTH  = 1 << OUTST_DEPTH_LG2;
    localparam logic [9:0] MPS_BEATS_W = 10'(MPS_BEATS);
    localparam logic [9:0] OFF_MASK    = 10'(MPS_BEATS - 1);

    typedef enum logic [1:0] {IDLE, AW, W} state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [8:0]            rem;
    logic [ID_WIDTH-1:0]   cur_id;
    logic [7:0]            sub_len;
    logic [7:0]            beat_cnt;

    logic [9:0] cur_off, room, rem_w, sub_beats;
    logic [7:0] sub_awlen;
    logic [8:0] sub_done, rem_after;
    logic [9:0] in_off, nsub_sum;
    logic [8:0] in_nsub;

    logic aw_in_hs, aw_out_hs, w_hs, mb_hs, sb_hs;

    logic [ID_WIDTH-1:0]        fifo_id   [FIFO_DEPTH];
    logic [8:0]                 fifo_nsub [FIFO_DEPTH];
    logic [OUTST_DEPTH_LG2-1:0] wr_ptr, rd_ptr;
    logic [OUTST_DEPTH_LG2:0]   fifo_cnt;
    logic                       fifo_full, fifo_empty;

    logic [8:0] sub_cnt;
    logic [1:0] acc_resp, merged_resp;

    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awsize, s_axi_awburst, s_axi_wlast, m_axi_bid};

    // Sub-burst sizing: stop at the end of the current payload window or at
    // the end of the original burst, whichever comes first.
    assign cur_off   = cur_addr[14:5] & OFF_MASK;
    assign room      = MPS_BEATS_W - cur_off;
    assign rem_w     = {1'b0, rem};
    assign sub_beats = (rem_w < room) ? rem_w : room;
    assign sub_awlen = 8'(sub_beats - 10'd1);
    assign sub_done  = {1'b0, sub_len} + 9'd1;
    assign rem_after = rem - sub_done;

    // Number of sub-bursts the incoming request will become, stored with its
    // ID so the B merge knows how many downstream responses to wait for.
    assign in_off   = s_axi_awaddr[14:5] & OFF_MASK;
    assign nsub_sum = in_off + {2'b0, s_axi_awlen} + MPS_BEATS_W;
    assign in_nsub  = 9'(nsub_sum >> (MPS_LG2 - 5));

    assign aw_in_hs  = s_axi_awvalid && s_axi_awready;
    assign aw_out_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs      = m_axi_wvalid && m_axi_wready;
    assign mb_hs     = m_axi_bvalid && m_axi_bready;
    assign sb_hs     = s_axi_bvalid && s_axi_bready;

    assign fifo_full  = (fifo_cnt == (OUTST_DEPTH_LG2+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);

    assign m_axi_awid    = cur_id;
    assign m_axi_awaddr  = cur_addr;
    assign m_axi_awsize  = 3'd5;
    assign m_axi_awburst = 2'b01;
    assign m_axi_wdata   = s_axi_wdata;
    assign m_axi_wstrb   = s_axi_wstrb;
    assign m_axi_bready  = !s_axi_bvalid && !fifo_empty;
    assign merged_resp   = (m_axi_bresp > acc_resp) ? m_axi_bresp : acc_resp;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // FSM next state: accept a request, issue each sub-burst AW, stream its W beats.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (aw_in_hs) state_next = AW;
            AW:   if (aw_out_hs) state_next = W;
            W:    if (w_hs && m_axi_wlast) state_next = (rem_after != 9'd0) ? AW : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: W channel is a straight pass-through while in W.
    always_comb begin
        s_axi_awready = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_awlen   = 8'd0;
        m_axi_wvalid  = 1'b0;
        s_axi_wready  = 1'b0;
        m_axi_wlast   = 1'b0;
        case (state)
            IDLE: s_axi_awready = !fifo_full;
            AW: begin
                m_axi_awvalid = 1'b1;
                m_axi_awlen   = sub_awlen;
            end
            W: begin
                m_axi_wvalid = s_axi_wvalid;
                s_axi_wready = m_axi_wready;
                m_axi_wlast  = (beat_cnt == sub_len);
            end
            default: ;
        endcase
    end

    // Burst walker: tracks the address and beats left of the original burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr <= '0;
            rem      <= 9'd0;
            cur_id   <= '0;
            sub_len  <= 8'd0;
            beat_cnt <= 8'd0;
        end else begin
            if (aw_in_hs) begin
                cur_addr <= s_axi_awaddr;
                rem      <= {1'b0, s_axi_awlen} + 9'd1;
                cur_id   <= s_axi_awid;
            end
            if (aw_out_hs) begin
                sub_len  <= sub_awlen;
                beat_cnt <= 8'd0;
            end
            if (w_hs) begin
                beat_cnt <= beat_cnt + 8'd1;
                if (m_axi_wlast) begin
                    cur_addr <= cur_addr + (ADDR_WIDTH'(sub_done) << 5);
                    rem      <= rem_after;
                end
            end
        end
    end

    // Outstanding-burst FIFO pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (aw_in_hs) wr_ptr <= wr_ptr + OUTST_DEPTH_LG2'(1);
            if (sb_hs)    rd_ptr <= rd_ptr + OUTST_DEPTH_LG2'(1);
            case ({aw_in_hs, sb_hs})
                2'b10:   fifo_cnt <= fifo_cnt + (OUTST_DEPTH_LG2+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (OUTST_DEPTH_LG2+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Outstanding-burst FIFO storage: original ID and expected sub-burst count.
    always_ff @(posedge clk) begin
        if (aw_in_hs) begin
            fifo_id[wr_ptr]   <= s_axi_awid;
            fifo_nsub[wr_ptr] <= in_nsub;
        end
    end

    // Response merge: keep the worst response across sub-bursts and raise one
    // upstream B once the last sub-burst of the head burst has answered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_axi_bvalid <= 1'b0;
            s_axi_bid    <= '0;
            s_axi_bresp  <= 2'b00;
            sub_cnt      <= 9'd0;
            acc_resp     <= 2'b00;
        end else begin
            if (sb_hs) s_axi_bvalid <= 1'b0;
            if (mb_hs) begin
                if (sub_cnt + 9'd1 == fifo_nsub[rd_ptr]) begin
                    s_axi_bvalid <= 1'b1;
                    s_axi_bid    <= fifo_id[rd_ptr];
                    s_axi_bresp  <= merged_resp;
                    sub_cnt      <= 9'd0;
                    acc_resp     <= 2'b00;
                end else begin
                    sub_cnt  <= sub_cnt + 9'd1;
                    acc_resp <= merged_resp;
                end
            end
        end
    end

endmodule

// File: tb/tb_pcie_axi_wr_splitter.sv
// tb_pcie_axi_wr_splitter
// Directed bench: table of bursts with hand-computed sub-burst splits, plus
// hand-written sequences for latency, FIFO-full back-pressure, random stalls
// and asynchronous reset in the middle of a W stream.
module tb_pcie_axi_wr_splitter;

    logic         clk = 1'b0;
    logic         rst;

    logic         s_axi_awvalid, s_axi_awready;
    logic [5:0]   s_axi_awid;
    logic [63:0]  s_axi_awaddr;
    logic [7:0]   s_axi_awlen;
    logic [2:0]   s_axi_awsize;
    logic [1:0]   s_axi_awburst;
    logic         s_axi_wvalid, s_axi_wready;
    logic [255:0] s_axi_wdata;
    logic [31:0]  s_axi_wstrb;
    logic         s_axi_wlast;
    logic         s_axi_bvalid, s_axi_bready;
    logic [5:0]   s_axi_bid;
    logic [1:0]   s_axi_bresp;
    logic         m_axi_awvalid, m_axi_awready;
    logic [5:0]   m_axi_awid;
    logic [63:0]  m_axi_awaddr;
    logic [7:0]   m_axi_awlen;
    logic [2:0]   m_axi_awsize;
    logic [1:0]   m_axi_awburst;
    logic         m_axi_wvalid, m_axi_wready;
    logic [255:0] m_axi_wdata;
    logic [31:0]  m_axi_wstrb;
    logic         m_axi_wlast;
    logic         m_axi_bvalid, m_axi_bready;
    logic [5:0]   m_axi_bid;
    logic [1:0]   m_axi_bresp;

    pcie_axi_wr_splitter dut (
        .clk(clk), .rst(rst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp)
    );

    typedef struct packed {
        logic [5:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
    } aw_t;

    typedef struct packed {
        logic [255:0] data;
        logic [31:0]  strb;
        logic         last;
    } w_t;

    typedef struct packed {
        logic [5:0] id;
        logic [1:0] resp;
    } b_t;

    typedef struct packed {
        logic [5:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [1:0]  nsub;
        logic [63:0] a0;
        logic [7:0]  l0;
        logic [63:0] a1;
        logic [7:0]  l1;
        logic [63:0] a2;
        logic [7:0]  l2;
        logic [1:0]  r0;
        logic [1:0]  r1;
        logic [1:0]  r2;
        logic [1:0]  exp_resp;
    } vec_t;

    aw_t        up_aw_q[$];
    w_t         up_w_q[$];
    w_t         exp_w[$];
    logic [1:0] m_resp_q[$];
    aw_t        obs_aw[$];
    w_t         obs_w[$];
    b_t         obs_sb[$];
    int         aw_acc_cyc[$];
    int         sb_cyc[$];
    int         m_b_pending;
    int         aw_ready_mode;
    int         w_ready_mode;
    bit         s_bready_en;
    bit         mb_seen;
    int         cyc;
    int         n_cmp = 0;
    int         n_fail = 0;
    vec_t       vecs[6];

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Absolute time limit so a wedged design can never hang the run.
    initial begin
        #600000;
        $display("[TB] FAIL global_timeout: simulation did not finish, required completion before limit");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic vec_t mkvec(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len,
                                   input logic [1:0] nsub,
                                   input logic [63:0] a0, input logic [7:0] l0,
                                   input logic [63:0] a1, input logic [7:0] l1,
                                   input logic [63:0] a2, input logic [7:0] l2,
                                   input logic [1:0] r0, input logic [1:0] r1, input logic [1:0] r2,
                                   input logic [1:0] exp_resp);
        vec_t v;
        v.id = id; v.addr = addr; v.len = len; v.nsub = nsub;
        v.a0 = a0; v.l0 = l0; v.a1 = a1; v.l1 = l1; v.a2 = a2; v.l2 = l2;
        v.r0 = r0; v.r1 = r1; v.r2 = r2; v.exp_resp = exp_resp;
        return v;
    endfunction

    task automatic clearTbState();
        up_aw_q.delete();
        up_w_q.delete();
        exp_w.delete();
        m_resp_q.delete();
        obs_aw.delete();
        obs_w.delete();
        obs_sb.delete();
        aw_acc_cyc.delete();
        sb_cyc.delete();
        m_b_pending = 0;
        mb_seen = 1'b0;
    endtask

    // Drive every DUT input from the bench queues and mode knobs.
    task automatic drive();
        s_axi_awsize  = 3'd5;
        s_axi_awburst = 2'b01;
        s_axi_wlast   = 1'b0;
        m_axi_bid     = 6'd0;
        s_axi_awvalid = (up_aw_q.size() > 0);
        s_axi_awid    = (up_aw_q.size() > 0) ? up_aw_q[0].id   : 6'd0;
        s_axi_awaddr  = (up_aw_q.size() > 0) ? up_aw_q[0].addr : 64'd0;
        s_axi_awlen   = (up_aw_q.size() > 0) ? up_aw_q[0].len  : 8'd0;
        s_axi_wvalid  = (up_w_q.size() > 0);
        s_axi_wdata   = (up_w_q.size() > 0) ? up_w_q[0].data : 256'd0;
        s_axi_wstrb   = (up_w_q.size() > 0) ? up_w_q[0].strb : 32'd0;
        s_axi_bready  = s_bready_en;
        m_axi_awready = (aw_ready_mode == 0) ? 1'b1 : (aw_ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        m_axi_wready  = (w_ready_mode == 0) ? 1'b1 : (w_ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        m_axi_bvalid  = (m_b_pending > 0);
        m_axi_bresp   = (m_b_pending > 0 && m_resp_q.size() > 0) ? m_resp_q[0] : 2'b00;
    endtask

    // One clock: drive, let combinational paths settle, record the handshakes
    // that will complete at the coming edge, then step past the edge.
    task automatic applyStimulus();
        aw_t a;
        w_t  wb;
        b_t  b;
        bit  new_last;
        drive();
        #1;
        mb_seen  = 1'b0;
        new_last = 1'b0;
        if (s_axi_awvalid && s_axi_awready) begin
            void'(up_aw_q.pop_front());
            aw_acc_cyc.push_back(cyc);
        end
        if (s_axi_wvalid && s_axi_wready) void'(up_w_q.pop_front());
        if (m_axi_awvalid && m_axi_awready) begin
            a.id = m_axi_awid; a.addr = m_axi_awaddr; a.len = m_axi_awlen;
            obs_aw.push_back(a);
        end
        if (m_axi_wvalid && m_axi_wready) begin
            wb.data = m_axi_wdata; wb.strb = m_axi_wstrb; wb.last = m_axi_wlast;
            obs_w.push_back(wb);
            new_last = m_axi_wlast;
        end
        if (m_axi_bvalid && m_axi_bready) begin
            m_b_pending--;
            if (m_resp_q.size() > 0) void'(m_resp_q.pop_front());
            mb_seen = 1'b1;
        end
        if (new_last) m_b_pending++;
        if (s_axi_bvalid && s_axi_bready) begin
            b.id = s_axi_bid; b.resp = s_axi_bresp;
            obs_sb.push_back(b);
            sb_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic waitSb(input int n, input int limit);
        for (int i = 0; i < limit && obs_sb.size() < n; i++) applyStimulus();
    endtask

    task automatic queueBurst(input logic [5:0] id, input logic [63:0] addr, input logic [7:0] len);
        aw_t a;
        w_t  wb;
        a.id = id; a.addr = addr; a.len = len;
        up_aw_q.push_back(a);
        for (int b = 0; b <= int'(len); b++) begin
            wb.data = rand256(); wb.strb = $urandom; wb.last = 1'b0;
            up_w_q.push_back(wb);
            exp_w.push_back(wb);
        end
    endtask

    // Run one table vector to completion and compare against its hand split.
    task automatic runVector(input vec_t v, input string name);
        logic [63:0] ea[3];
        logic [7:0]  el[3];
        logic [1:0]  er[3];
        int          j;
        int          k;
        bit          exp_last;
        ea[0] = v.a0; ea[1] = v.a1; ea[2] = v.a2;
        el[0] = v.l0; el[1] = v.l1; el[2] = v.l2;
        er[0] = v.r0; er[1] = v.r1; er[2] = v.r2;
        clearTbState();
        queueBurst(v.id, v.addr, v.len);
        for (int s = 0; s < int'(v.nsub); s++) m_resp_q.push_back(er[s]);
        waitSb(1, 300);
        repeat (5) applyStimulus();
        checkOutput({name, "_sb_count"}, 256'(obs_sb.size()), 256'd1);
        checkOutput({name, "_aw_count"}, 256'(obs_aw.size()), 256'(v.nsub));
        for (int s = 0; s < int'(v.nsub) && s < obs_aw.size(); s++) begin
            checkOutput($sformatf("%s_aw%0d_addr", name, s), 256'(obs_aw[s].addr), 256'(ea[s]));
            checkOutput($sformatf("%s_aw%0d_len", name, s), 256'(obs_aw[s].len), 256'(el[s]));
            checkOutput($sformatf("%s_aw%0d_id", name, s), 256'(obs_aw[s].id), 256'(v.id));
        end
        checkOutput({name, "_w_count"}, 256'(obs_w.size()), 256'(int'(v.len) + 1));
        j = 0;
        k = 0;
        for (int b = 0; b < obs_w.size() && b < exp_w.size(); b++) begin
            exp_last = (j < int'(v.nsub)) ? (k == int'(el[j])) : 1'b0;
            checkOutput($sformatf("%s_w%0d_data", name, b), obs_w[b].data, exp_w[b].data);
            checkOutput($sformatf("%s_w%0d_strb", name, b), 256'(obs_w[b].strb), 256'(exp_w[b].strb));
            checkOutput($sformatf("%s_w%0d_last", name, b), 256'(obs_w[b].last), 256'(exp_last));
            if (exp_last) begin
                j++;
                k = 0;
            end else begin
                k++;
            end
        end
        if (obs_sb.size() > 0) begin
            checkOutput({name, "_bid"}, 256'(obs_sb[0].id), 256'(v.id));
            checkOutput({name, "_bresp"}, 256'(obs_sb[0].resp), 256'(v.exp_resp));
        end
    endtask

    initial begin
        // id, addr, len, nsub, sub AWs {addr,len} x3, downstream bresp x3, merged bresp
        vecs[0] = mkvec(6'h05, 64'h1000, 8'd3, 2'd1, 64'h1000, 8'd3, 64'h0, 8'd0, 64'h0, 8'd0,
                        2'b00, 2'b00, 2'b00, 2'b00);
        vecs[1] = mkvec(6'h09, 64'h1040, 8'd7, 2'd3, 64'h1040, 8'd1, 64'h1080, 8'd3, 64'h1100, 8'd1,
                        2'b00, 2'b00, 2'b00, 2'b00);
        vecs[2] = mkvec(6'h2A, 64'h1040, 8'd7, 2'd3, 64'h1040, 8'd1, 64'h1080, 8'd3, 64'h1100, 8'd1,
                        2'b00, 2'b10, 2'b00, 2'b10);
        vecs[3] = mkvec(6'h03, 64'h1FE0, 8'd1, 2'd2, 64'h1FE0, 8'd0, 64'h2000, 8'd0, 64'h0, 8'd0,
                        2'b00, 2'b00, 2'b00, 2'b00);
        vecs[4] = mkvec(6'h3F, 64'h2060, 8'd4, 2'd2, 64'h2060, 8'd0, 64'h2080, 8'd3, 64'h0, 8'd0,
                        2'b01, 2'b11, 2'b00, 2'b11);
        vecs[5] = mkvec(6'h11, 64'h3000, 8'd5, 2'd2, 64'h3000, 8'd3, 64'h3080, 8'd1, 64'h0, 8'd0,
                        2'b11, 2'b01, 2'b00, 2'b11);

        cyc = 0;
        aw_ready_mode = 0;
        w_ready_mode = 0;
        s_bready_en = 1'b1;
        clearTbState();
        rst = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;

        // Reset values while reset is held.
        checkOutput("rst_s_awready", 256'(s_axi_awready), 256'd1);
        checkOutput("rst_s_wready", 256'(s_axi_wready), 256'd0);
        checkOutput("rst_s_bvalid", 256'(s_axi_bvalid), 256'd0);
        checkOutput("rst_s_bid", 256'(s_axi_bid), 256'd0);
        checkOutput("rst_s_bresp", 256'(s_axi_bresp), 256'd0);
        checkOutput("rst_m_awvalid", 256'(m_axi_awvalid), 256'd0);
        checkOutput("rst_m_awaddr", 256'(m_axi_awaddr), 256'd0);
        checkOutput("rst_m_awlen", 256'(m_axi_awlen), 256'd0);
        checkOutput("rst_m_awid", 256'(m_axi_awid), 256'd0);
        checkOutput("rst_m_awsize", 256'(m_axi_awsize), 256'd5);
        checkOutput("rst_m_awburst", 256'(m_axi_awburst), 256'd1);
        checkOutput("rst_m_wvalid", 256'(m_axi_wvalid), 256'd0);
        checkOutput("rst_m_bready", 256'(m_axi_bready), 256'd0);
        rst = 1'b0;

        // Latency: AW accepted at N shows m_awvalid at N+1, held under stall;
        // final downstream B at N shows s_bvalid at N+1.
        $display("[TB] latency sequence");
        clearTbState();
        aw_ready_mode = 2;
        queueBurst(6'h01, 64'h1000, 8'd0);
        m_resp_q.push_back(2'b00);
        applyStimulus();
        checkOutput("lat_aw_accepted", 256'(aw_acc_cyc.size()), 256'd1);
        checkOutput("lat_m_awvalid_n1", 256'(m_axi_awvalid), 256'd1);
        checkOutput("lat_s_awready_busy", 256'(s_axi_awready), 256'd0);
        repeat (2) applyStimulus();
        checkOutput("lat_awvalid_held", 256'(m_axi_awvalid), 256'd1);
        checkOutput("lat_awaddr_held", 256'(m_axi_awaddr), 256'h1000);
        checkOutput("lat_awlen_held", 256'(m_axi_awlen), 256'd0);
        checkOutput("lat_awid_held", 256'(m_axi_awid), 256'd1);
        aw_ready_mode = 0;
        for (int i = 0; i < 30 && !mb_seen; i++) applyStimulus();
        checkOutput("lat_m_b_seen", 256'(mb_seen), 256'd1);
        checkOutput("lat_s_bvalid_n1", 256'(s_axi_bvalid), 256'd1);
        checkOutput("lat_s_bid", 256'(s_axi_bid), 256'd1);
        waitSb(1, 20);
        checkOutput("lat_sb_count", 256'(obs_sb.size()), 256'd1);

        // Table-driven bursts.
        $display("[TB] vector table");
        for (int i = 0; i < 6; i++) runVector(vecs[i], $sformatf("vec%0d", i));

        // FIFO full: four bursts outstanding blocks the fifth until a B pops.
        $display("[TB] fifo full sequence");
        clearTbState();
        s_bready_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            queueBurst(6'(10 + i), 64'h4000 + 64'(i * 32), 8'd0);
            m_resp_q.push_back(2'b00);
        end
        repeat (60) applyStimulus();
        checkOutput("full_aw_accepted", 256'(aw_acc_cyc.size()), 256'd4);
        checkOutput("full_m_aw_count", 256'(obs_aw.size()), 256'd4);
        checkOutput("full_s_awready", 256'(s_axi_awready), 256'd0);
        checkOutput("full_s_bvalid_held", 256'(s_axi_bvalid), 256'd1);
        checkOutput("full_s_bid_held", 256'(s_axi_bid), 256'd10);
        s_bready_en = 1'b1;
        waitSb(5, 150);
        checkOutput("full_sb_count", 256'(obs_sb.size()), 256'd5);
        for (int i = 0; i < 5 && i < obs_sb.size(); i++) begin
            checkOutput($sformatf("full_sb%0d_id", i), 256'(obs_sb[i].id), 256'(10 + i));
            checkOutput($sformatf("full_sb%0d_resp", i), 256'(obs_sb[i].resp), 256'd0);
        end
        checkOutput("full_aw5_accepted", 256'(aw_acc_cyc.size()), 256'd5);
        if (aw_acc_cyc.size() == 5 && sb_cyc.size() > 0)
            checkOutput("full_aw5_after_b", 256'(aw_acc_cyc[4] > sb_cyc[0]), 256'd1);

        // Long burst with random downstream stalls: 64 sub-bursts of 4 beats.
        $display("[TB] stall sequence");
        clearTbState();
        aw_ready_mode = 1;
        w_ready_mode = 1;
        queueBurst(6'h07, 64'h0, 8'd255);
        for (int s = 0; s < 64; s++) m_resp_q.push_back(2'b00);
        waitSb(1, 3000);
        checkOutput("stall_sb_count", 256'(obs_sb.size()), 256'd1);
        checkOutput("stall_aw_count", 256'(obs_aw.size()), 256'd64);
        for (int s = 0; s < 64 && s < obs_aw.size(); s++) begin
            checkOutput($sformatf("stall_aw%0d_addr", s), 256'(obs_aw[s].addr), 256'(s * 128));
            checkOutput($sformatf("stall_aw%0d_len", s), 256'(obs_aw[s].len), 256'd3);
        end
        checkOutput("stall_w_count", 256'(obs_w.size()), 256'd256);
        for (int b = 0; b < 256 && b < obs_w.size(); b++) begin
            checkOutput($sformatf("stall_w%0d_data", b), obs_w[b].data, exp_w[b].data);
            checkOutput($sformatf("stall_w%0d_last", b), 256'(obs_w[b].last), 256'((b % 4) == 3));
        end

        // Asynchronous reset in the middle of a W stream.
        $display("[TB] reset mid-burst sequence");
        clearTbState();
        aw_ready_mode = 0;
        w_ready_mode = 0;
        queueBurst(6'h02, 64'h5000, 8'd15);
        for (int i = 0; i < 40 && obs_w.size() < 2; i++) applyStimulus();
        checkOutput("mid_pre_wvalid", 256'(m_axi_wvalid), 256'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_m_awvalid", 256'(m_axi_awvalid), 256'd0);
        checkOutput("mid_rst_m_wvalid", 256'(m_axi_wvalid), 256'd0);
        checkOutput("mid_rst_s_wready", 256'(s_axi_wready), 256'd0);
        checkOutput("mid_rst_s_bvalid", 256'(s_axi_bvalid), 256'd0);
        checkOutput("mid_rst_s_awready", 256'(s_axi_awready), 256'd1);
        checkOutput("mid_rst_m_bready", 256'(m_axi_bready), 256'd0);
        clearTbState();
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) applyStimulus();
        checkOutput("mid_no_partial_b", 256'(obs_sb.size()), 256'd0);
        checkOutput("mid_no_stray_aw", 256'(obs_aw.size()), 256'd0);
        runVector(vecs[1], "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
